m_wb_sram16: RTL and testbench
==============================

Name: m_wb_sram16

Overview:
- Wishbone B4 classic slave that turns 32-bit core accesses into one or two 16-bit accesses on an asynchronous external SRAM.
- Sits directly downstream of the midgetv iCE40 SRAM-build simulation top and serves its SRAM address space (SRAMADRWIDTH).
- Each 16-bit half uses a setup cycle plus a programmable number of strobe cycles.
- Halves with no enabled byte lanes are skipped.

Parameters:
- SRAMADRWIDTH, 16, address width of the 16-bit-wide SRAM. Wishbone word address width is SRAMADRWIDTH-1.
- WAITSTATES, 1, extra strobe cycles per half. Legal range 0..7.

Ports:
- CLK_I  in  1  clock; all state changes on the rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  1 = write.
- SEL_I  in  4  byte lane enables.
- ADR_I  in  SRAMADRWIDTH-1  32-bit word address.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data.
- ACK_O  out  1  single-cycle acknowledge.
- sram_a  out  SRAMADRWIDTH  SRAM halfword address; {ADR_I,0} for the low half, {ADR_I,1} for the high half.
- sram_d_o  out  16  SRAM write data.
- sram_d_i  in  16  SRAM read data.
- sram_d_oe  out  1  data bus output enable (1 = drive sram_d_o).
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_lb_n  out  1  lower byte enable, active low.
- sram_ub_n  out  1  upper byte enable, active low.

Behaviour:
- Interface: one clock CLK_I; RST_I is synchronous and active-high.
- Reset values: ACK_O=0, DAT_O=0, sram_ce_n=sram_oe_n=sram_we_n=sram_lb_n=sram_ub_n=1, sram_d_oe=0, sram_a=0, sram_d_o=0, state IDLE. All outputs are registered.
- States: IDLE, LO_SETUP, LO_STRB, HI_SETUP, HI_STRB, ACK.
- IDLE:
  - Starts a request when CYC_I & STB_I & !ACK_O. Latches ADR_I, WE_I, SEL_I and DAT_I.
  - Next state: LO_SETUP if SEL_I[1:0]!=0; else HI_SETUP if SEL_I[3:2]!=0; else ACK.
- SETUP (one cycle):
  - sram_ce_n=0; sram_a valid.
  - lb_n/ub_n = ~SEL pair for that half.
  - Write: sram_d_oe=1, sram_d_o = that half of the latched data.
  - sram_we_n and sram_oe_n stay 1.
- STRB (WAITSTATES+1 cycles, counted by a 3-bit down-counter):
  - Read: oe_n=0. sram_d_i is captured into the matching DAT_O half on the last STRB cycle.
  - Write: we_n=0; sram_d_oe and data are held.
  - Exit: LO_STRB goes to HI_SETUP if the high half is enabled, else to ACK. HI_STRB goes to ACK.
- ACK: ACK_O=1 for exactly one cycle; all SRAM strobes inactive; then IDLE. A request still asserted in the cycle ACK_O is high is not restarted.
- DAT_O masking: byte lanes with SEL=0 read back 0. DAT_O holds its value until the next read completes. Writes do not change DAT_O.
- Latency (request first seen in IDLE at cycle N; W = WAITSTATES):
  - both halves: ACK_O in cycle N+5+2W.
  - single half: ACK_O in cycle N+3+W.
  - SEL_I=0: ACK_O in cycle N+1, with no SRAM activity.
- sram_we_n is never low in the same cycle that sram_d_oe changes (setup ensures address/data-before-WE). sram_oe_n and sram_d_oe are never both active.
- Abort: CYC_I low in any non-IDLE state → IDLE at the next edge. Strobes are deasserted, no ACK_O, and DAT_O is not updated. A write half already strobed may have completed.
- RST_I mid-operation: same as abort, and all outputs take their reset values.

Optional Feature:
- Macro: SRAM_SIMMEM_EN.
- Defined:
  - The module instantiates a behavioural memory of 2^SRAMADRWIDTH x 16 bits, initialised to 0.
  - A write occurs on the rising edge of sram_we_n, honouring lb_n/ub_n.
  - Reads return mem[sram_a] combinationally while sram_oe_n=0; otherwise 0.
  - The sram_d_i port is ignored.
  - Intended for verilator builds of the SRAM simulation top.
- Not defined: no array; read data comes only from sram_d_i.

Test Plan:
- Reset, then idle for 10 cycles → all SRAM strobes high, sram_d_oe=0, ACK_O=0, DAT_O=0.
- W=1, write ADR=0x0012, SEL=1111, DAT=0xDEADBEEF → halfword 0x24=0xBEEF, 0x25=0xDEAD; ACK_O in cycle N+7; we_n low exactly 2 cycles per half.
- Read back ADR=0x0012, SEL=1111 → DAT_O=0xDEADBEEF with ACK_O. Read with SEL=0100 → only HI half accessed, ub_n=1, lb_n=0, DAT_O=0x00AD0000, ACK_O at N+4.
- SEL=0000 request → ACK_O at N+1, sram_ce_n never low.
- Drop CYC_I during HI_STRB of a write, then assert RST_I during LO_STRB of a read → no ACK_O either time, strobes high next cycle; a subsequent normal read completes correctly.
- W=0 and W=7 back-to-back read/write bursts with STB_I held across ACK_O → one ACK_O per transaction; latencies 5 and 19 cycles respectively.

Source files
------------

// File: rtl/m_wb_sram16.sv
// m_wb_sram16: Wishbone B4 classic slave that maps 32-bit accesses onto one or
// two 16-bit accesses of an asynchronous external SRAM. Each enabled half takes
// a one-cycle setup phase plus WAITSTATES+1 strobe cycles. A half whose byte
// lanes are all disabled is skipped.
// Optional build macro SRAM_SIMMEM_EN: adds an internal behavioural SRAM and
// ignores sram_d_i. This is intended for simulation builds only.
module m_wb_sram16 #(
  parameter int SRAMADRWIDTH = 16,
  parameter int WAITSTATES   = 1
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [3:0]              SEL_I,
  input  logic [SRAMADRWIDTH-2:0] ADR_I,
  input  logic [31:0]             DAT_I,
  output logic [31:0]             DAT_O,
  output logic                    ACK_O,
  output logic [SRAMADRWIDTH-1:0] sram_a,
  output logic [15:0]             sram_d_o,
  input  logic [15:0]             sram_d_i,
  output logic                    sram_d_oe,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic                    sram_lb_n,
  output logic                    sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE,
    LO_SETUP,
    LO_STRB,
    HI_SETUP,
    HI_STRB,
    ACK
  } state_t;

  localparam logic [2:0] WS = 3'(WAITSTATES);

  state_t                  state_q;
  logic [SRAMADRWIDTH-2:0] adr_q;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [31:0]             wdat_q;
  logic [15:0]             rlo_q;
  logic [2:0]              cnt_q;
  logic [15:0]             rd_data;

  // Zero the byte lanes of a halfword that are not selected.
  function automatic logic [15:0] mask16(input logic [15:0] d, input logic [1:0] s);
    return {(s[1] ? d[15:8] : 8'h00), (s[0] ? d[7:0] : 8'h00)};
  endfunction

`ifdef SRAM_SIMMEM_EN
  logic [15:0] mem_q [0:(2**SRAMADRWIDTH)-1] = '{default: '0};

  // Address, data and lane enables are held for the whole strobe. Writing on
  // every cycle that we_n is low therefore leaves the same contents as a single
  // write on the rising edge of we_n.
  always_ff @(posedge CLK_I) begin
    if (!sram_we_n) begin
      if (!sram_lb_n) mem_q[sram_a][7:0]  <= sram_d_o[7:0];
      if (!sram_ub_n) mem_q[sram_a][15:8] <= sram_d_o[15:8];
    end
  end

  // Behavioural read port, active only while the output enable is asserted.
  always_comb begin
    rd_data = '0;
    if (!sram_oe_n) rd_data = mem_q[sram_a];
  end
`else
  // Read data comes straight from the external SRAM data bus.
  always_comb begin
    rd_data = sram_d_i;
  end
`endif

  // Access sequencer. Every output is registered, so each transition loads the
  // output values that belong to the state being entered.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      ACK_O     <= 1'b0;
      DAT_O     <= '0;
      sram_a    <= '0;
      sram_d_o  <= '0;
      sram_d_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdat_q    <= '0;
      rlo_q     <= '0;
      cnt_q     <= '0;
    end else if (state_q != IDLE && !CYC_I) begin
      state_q   <= IDLE;
      ACK_O     <= 1'b0;
      sram_d_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (CYC_I && STB_I && !ACK_O) begin
            adr_q  <= ADR_I;
            we_q   <= WE_I;
            sel_q  <= SEL_I;
            wdat_q <= DAT_I;
            rlo_q  <= '0;
            if (|SEL_I[1:0]) begin
              state_q   <= LO_SETUP;
              sram_ce_n <= 1'b0;
              sram_a    <= {ADR_I, 1'b0};
              sram_lb_n <= ~SEL_I[0];
              sram_ub_n <= ~SEL_I[1];
              sram_d_oe <= WE_I;
              sram_d_o  <= DAT_I[15:0];
            end else if (|SEL_I[3:2]) begin
              state_q   <= HI_SETUP;
              sram_ce_n <= 1'b0;
              sram_a    <= {ADR_I, 1'b1};
              sram_lb_n <= ~SEL_I[2];
              sram_ub_n <= ~SEL_I[3];
              sram_d_oe <= WE_I;
              sram_d_o  <= DAT_I[31:16];
            end else begin
              state_q <= ACK;
              ACK_O   <= 1'b1;
              if (!WE_I) DAT_O <= '0;
            end
          end
        end

        LO_SETUP, HI_SETUP: begin
          cnt_q <= WS;
          if (we_q) sram_we_n <= 1'b0;
          else      sram_oe_n <= 1'b0;
          state_q <= (state_q == LO_SETUP) ? LO_STRB : HI_STRB;
        end

        LO_STRB: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            rlo_q     <= mask16(rd_data, sel_q[1:0]);
            if (|sel_q[3:2]) begin
              // sram_d_oe is left unchanged so that data stays driven across halves.
              state_q   <= HI_SETUP;
              sram_a    <= {adr_q, 1'b1};
              sram_lb_n <= ~sel_q[2];
              sram_ub_n <= ~sel_q[3];
              sram_d_o  <= wdat_q[31:16];
            end else begin
              state_q   <= ACK;
              ACK_O     <= 1'b1;
              sram_ce_n <= 1'b1;
              sram_lb_n <= 1'b1;
              sram_ub_n <= 1'b1;
              sram_d_oe <= 1'b0;
              if (!we_q) DAT_O <= {16'h0000, mask16(rd_data, sel_q[1:0])};
            end
          end
        end

        HI_STRB: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            state_q   <= ACK;
            ACK_O     <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_d_oe <= 1'b0;
            if (!we_q) DAT_O <= {mask16(rd_data, sel_q[3:2]), rlo_q};
          end
        end

        ACK: begin
          ACK_O   <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_wb_sram16.sv
// tb_m_wb_sram16: directed bench for m_wb_sram16. It uses three instances with
// WAITSTATES = 1, 0 and 7, each attached to a behavioural asynchronous SRAM.
// A scoreboard queue holds the expected latency and read data of every
// transaction.
module tb_m_wb_sram16;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc  [NI];
  logic        stb  [NI];
  logic        we   [NI];
  logic [3:0]  sel  [NI];
  logic [14:0] adr  [NI];
  logic [31:0] dati [NI];
  logic [31:0] dato [NI];
  logic        ack  [NI];
  logic [15:0] sa   [NI];
  logic [15:0] sdo  [NI];
  logic [15:0] sdi  [NI];
  logic        doe  [NI];
  logic        ce_n [NI];
  logic        oe_n [NI];
  logic        we_n [NI];
  logic        lb_n [NI];
  logic        ub_n [NI];

  bit [15:0] dmem [NI][65536];

  for (genvar g = 0; g < NI; g++) begin : u
    m_wb_sram16 #(
      .SRAMADRWIDTH(16),
      .WAITSTATES  ((g == 0) ? 1 : ((g == 1) ? 0 : 7))
    ) dut (
      .CLK_I    (clk),
      .RST_I    (rst),
      .CYC_I    (cyc[g]),
      .STB_I    (stb[g]),
      .WE_I     (we[g]),
      .SEL_I    (sel[g]),
      .ADR_I    (adr[g]),
      .DAT_I    (dati[g]),
      .DAT_O    (dato[g]),
      .ACK_O    (ack[g]),
      .sram_a   (sa[g]),
      .sram_d_o (sdo[g]),
      .sram_d_i (sdi[g]),
      .sram_d_oe(doe[g]),
      .sram_ce_n(ce_n[g]),
      .sram_oe_n(oe_n[g]),
      .sram_we_n(we_n[g]),
      .sram_lb_n(lb_n[g]),
      .sram_ub_n(ub_n[g])
    );
    assign sdi[g] = (oe_n[g] === 1'b0) ? dmem[g][sa[g]] : 16'h0000;
  end

  function automatic int wsof(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
  endfunction

  // SRAM model and protocol monitor
  int          ce_cnt  [NI];
  int          we_cnt  [NI];
  int          ack_cnt [NI];
  int          viol    [NI];
  logic [15:0] last_a  [NI];
  logic        last_lb [NI];
  logic        last_ub [NI];
  logic        doe_prev[NI];
  logic        wen_prev[NI];
  logic [15:0] pa [NI];
  logic [15:0] pd [NI];
  logic        plb[NI];
  logic        pub[NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst === 1'b0) begin
        // Write commits on the rising edge of we_n, using values held during the strobe.
        if (we_n[k] === 1'b1 && wen_prev[k] === 1'b0) begin
          if (!plb[k]) dmem[k][pa[k]][7:0]  = pd[k][7:0];
          if (!pub[k]) dmem[k][pa[k]][15:8] = pd[k][15:8];
        end
        if (we_n[k] === 1'b0) begin
          pa[k] = sa[k]; pd[k] = sdo[k]; plb[k] = lb_n[k]; pub[k] = ub_n[k];
          we_cnt[k]++;
        end
        if (ce_n[k] === 1'b0) begin
          ce_cnt[k]++;
          last_a[k] = sa[k]; last_lb[k] = lb_n[k]; last_ub[k] = ub_n[k];
        end
        if (ack[k] === 1'b1) ack_cnt[k]++;
        if (oe_n[k] === 1'b0 && doe[k] === 1'b1) viol[k]++;
        if (we_n[k] === 1'b0 && doe[k] !== doe_prev[k]) viol[k]++;
      end
      doe_prev[k] = doe[k];
      wen_prev[k] = we_n[k];
    end
  end

  // Checking and scoreboard
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          k;
    logic [31:0] dat;
    int          lat;
  } exp_t;
  exp_t        sbq[$];
  bit [15:0]   refm[int];
  logic [31:0] last_rd[NI];

  function automatic logic [15:0] refrd(int k, logic [15:0] a);
    int key;
    key = k * 65536 + int'(a);
    return refm.exists(key) ? refm[key] : 16'h0000;
  endfunction

  function automatic logic [31:0] lanemask(logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // This task is entered 1 time unit after a rising edge. When off=1, the
  // request is driven during the previous transaction's ACK cycle, so the
  // DUT first observes it one cycle later.
  task automatic xact(input int k, input bit w, input logic [3:0] s, input logic [14:0] ad,
                      input logic [31:0] d, input int off, input bit hold);
    exp_t        e;
    int          n;
    int          ws;
    logic [31:0] cur;
    ws = wsof(k);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = ad; dati[k] = d;
    cur = {refrd(k, {ad, 1'b1}), refrd(k, {ad, 1'b0})};
    e.k   = k;
    e.lat = off + (((|s[1:0]) && (|s[3:2])) ? 5 + 2 * ws : ((|s) ? 3 + ws : 1));
    if (w) begin
      cur = (cur & ~lanemask(s)) | (d & lanemask(s));
      refm[k * 65536 + int'({ad, 1'b0})] = cur[15:0];
      refm[k * 65536 + int'({ad, 1'b1})] = cur[31:16];
      e.dat = last_rd[k];
    end else begin
      e.dat = cur & lanemask(s);
      last_rd[k] = e.dat;
    end
    sbq.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack[k] !== 1'b1 && n < 80);
    e = sbq.pop_front();
    check($sformatf("k%0d_ack_latency", e.k), 32'(n), 32'(e.lat));
    check($sformatf("k%0d_dat_o", e.k), dato[k], e.dat);
    if (!hold) begin
      cyc[k] = 1'b0; stb[k] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  int c0;
  int a0;

  initial begin
    for (int k = 0; k < NI; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; sel[k] = '0; adr[k] = '0; dati[k] = '0;
      last_rd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Idle after reset
    check("rst_ack",  ack[0],  1'b0);
    check("rst_dat",  dato[0], 32'h0);
    check("rst_ce",   ce_n[0], 1'b1);
    check("rst_oe",   oe_n[0], 1'b1);
    check("rst_we",   we_n[0], 1'b1);
    check("rst_lb",   lb_n[0], 1'b1);
    check("rst_ub",   ub_n[0], 1'b1);
    check("rst_doe",  doe[0],  1'b0);
    check("rst_a",    sa[0],   16'h0);
    check("rst_ack1", ack[1],  1'b0);
    check("rst_ack2", ack[2],  1'b0);

    // W=1 full write, then read back
    c0 = we_cnt[0];
    xact(0, 1'b1, 4'hF, 15'h0012, 32'hDEADBEEF, 0, 1'b0);
    check("mem_0x24", dmem[0][16'h0024], 16'hBEEF);
    check("mem_0x25", dmem[0][16'h0025], 16'hDEAD);
    check("we_low_cycles", 32'(we_cnt[0] - c0), 32'd4);
    xact(0, 1'b0, 4'hF, 15'h0012, 32'h0, 0, 1'b0);

    // Single byte in the high half
    c0 = ce_cnt[0];
    xact(0, 1'b0, 4'b0100, 15'h0012, 32'h0, 0, 1'b0);
    check("sel4_ce_cycles", 32'(ce_cnt[0] - c0), 32'd3);
    check("sel4_addr", last_a[0], 16'h0025);
    check("sel4_lb_n", last_lb[0], 1'b0);
    check("sel4_ub_n", last_ub[0], 1'b1);

    // No lanes enabled: immediate ACK and no SRAM cycle; DAT_O must hold
    c0 = ce_cnt[0];
    xact(0, 1'b1, 4'b0000, 15'h0030, 32'h55555555, 0, 1'b0);
    check("sel0_ce_cycles", 32'(ce_cnt[0] - c0), 32'd0);

    // Abort of a write during HI_STRB
    a0 = ack_cnt[0];
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 15'h0040; dati[0] = 32'h12345678;
    repeat (5) @(posedge clk);
    #1;
    check("abort_in_hi_strb", we_n[0], 1'b0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_we_n", we_n[0], 1'b1);
    check("abort_ce_n", ce_n[0], 1'b1);
    check("abort_doe",  doe[0],  1'b0);
    check("abort_ack",  ack[0],  1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during LO_STRB of a read
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; adr[0] = 15'h0012;
    repeat (2) @(posedge clk);
    #1;
    check("rstrd_in_lo_strb", oe_n[0], 1'b0);
    rst = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #1;
    check("rstrd_ack",  ack[0],  1'b0);
    check("rstrd_dat",  dato[0], 32'h0);
    check("rstrd_oe_n", oe_n[0], 1'b1);
    check("rstrd_ce_n", ce_n[0], 1'b1);
    check("rstrd_a",    sa[0],   16'h0);
    rst = 1'b0;
    last_rd[0] = '0;
    @(posedge clk); #1;
    check("abort_no_ack", 32'(ack_cnt[0] - a0), 32'd0);
    xact(0, 1'b0, 4'hF, 15'h0012, 32'h0, 0, 1'b0);

    // Back-to-back bursts with STB held through ACK, for W=0 and W=7
    for (int k = 1; k < NI; k++) begin
      a0 = ack_cnt[k];
      xact(k, 1'b1, 4'hF,    15'h0100, 32'hA5A51234, 0, 1'b1);
      xact(k, 1'b0, 4'hF,    15'h0100, 32'h0,        1, 1'b1);
      xact(k, 1'b1, 4'b1001, 15'h0101, 32'h11223344, 1, 1'b1);
      xact(k, 1'b0, 4'hF,    15'h0101, 32'h0,        1, 1'b0);
      check($sformatf("k%0d_burst_acks", k), 32'(ack_cnt[k] - a0), 32'd4);
    end

    repeat (2) @(posedge clk);
    #1;
    check("k0_total_acks", 32'(ack_cnt[0]), 32'd5);
    check("protocol_viol", 32'(viol[0] + viol[1] + viol[2]), 32'd0);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
